aclint_mmio: RTL

Memory-mapped machine-level timer and software-interrupt device (ACLINT MTIMER + MSWI, CLINT-compatible offsets) for a single hart. It owns `mtime`, `mtimecmp` and `msip`, serves loads and stores from the data-bus side, and drives the `mtip`/`msip` levels into the master side of `aclint_if`. The CSR unit samples those levels into `mip`. The block is the direct upstream producer of the machine timer and software interrupt sources.

---
 rtl/aclint_mmio.sv | 125 ++++++++++++
 1 files changed

// File: rtl/aclint_mmio.sv
// ACLINT MTIMER + MSWI for one hart: mtime, mtimecmp, msip behind a
// valid/ready bus with a 1-cycle response; drives mtip/msip levels.
//
// Ports:
//   clk, rst                       clock, sync active-high reset
//   req_valid/req_ready            request handshake
//   req_addr/req_wen/req_wdata/req_wmask  request payload
//   rsp_valid/rsp_rdata            one-cycle response strobe and load data
//   mtip, msip                     interrupt pending levels
module aclint_mmio #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        mtip,
  output logic        msip
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [63:0] mtime_q, mtimecmp_q, rdata_q;
  logic [15:0] div_cnt_q;
  logic        msip_q, mtip_q;

  logic        accept, hit, tick;
  logic        sel_msip, sel_cmp, sel_time;
  logic [12:0] off;
  logic [63:0] bmask, rd_val;
  logic [63:0] cmp_new, time_new;
  logic        unused_ok;

  assign off      = req_addr[15:3];
  assign hit      = req_addr[63:16] == BASE_ADDR[63:16];
  assign sel_msip = hit && off == 13'h0000;
  assign sel_cmp  = hit && off == 13'h0800;
  assign sel_time = hit && off == 13'h17FF;
  assign tick     = div_cnt_q == DIV_LAST;
  assign accept   = req_ready && req_valid;

  assign unused_ok = ^req_addr[2:0];

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++) begin
      bmask[i*8 +: 8] = {8{req_wmask[i]}};
    end
  end

  assign cmp_new  = (mtimecmp_q & ~bmask)
                  | (req_wdata & bmask);
  assign time_new = (mtime_q & ~bmask)
                  | (req_wdata & bmask);

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_msip: rd_val = {63'b0, msip_q};
      sel_cmp:  rd_val = mtimecmp_q;
      sel_time: rd_val = mtime_q;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      div_cnt_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= tick ? 16'd0 : div_cnt_q + 16'd1;
      // a store to mtime wins over a coincident tick
      if (accept && req_wen && sel_time)
        mtime_q <= time_new;
      else if (tick)
        mtime_q <= mtime_q + 64'd1;
      if (accept && req_wen && sel_cmp)
        mtimecmp_q <= cmp_new;
      if (accept && req_wen && sel_msip
          && req_wmask[0])
        msip_q <= req_wdata[0];
      mtip_q  <= mtime_q >= mtimecmp_q;
      rdata_q <= (accept && !req_wen)
               ? rd_val : '0;
    end
  end

  assign rsp_rdata = rdata_q;
  assign mtip      = mtip_q;
  assign msip      = msip_q;

endmodule
